// File: rtl/lfsr_share_ctrl.sv
// Purpose: shares one 8-bit LFSR between N requesters: seeds it, arbitrates round-robin, returns one stepped value per grant.
// Latency: a request sampled in IDLE gets gnt on the next cycle and rsp_valid STEPS+2 cycles after sampling; back-to-back grant period is STEPS+3.
// Backpressure: requests are level-sensitive and wait in IDLE; a pending reseed wins over requests and a grant cannot be aborted except by reset.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req[N]               per-requester level request
//   seed_in[8]           seed value, sampled when a seed load starts
//   reseed_req           single-cycle reseed pulse (remembered while busy)
//   gnt[N]               one-hot grant, held from first step through delivery
//   rsp_valid[N]         one-hot, one-cycle response strobe
//   rsp_data[8]          captured random value, held until the next capture
//   busy                 high whenever the controller is not idle
//   lfsr_en              LFSR step enable
//   lfsr_seed_en         LFSR seed load enable
//   lfsr_seed[8]         LFSR seed data
//   lfsr_rand[8]         current LFSR register value

module lfsr_share_ctrl #(
  parameter int         N           = 4,
  parameter int         STEPS       = 4,
  parameter int         SEED_CYCLES = 2,
  parameter logic [7:0] SAFE_SEED   = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [7:0]   seed_in,
  input  logic         reseed_req,
  output logic [N-1:0] gnt,
  output logic [N-1:0] rsp_valid,
  output logic [7:0]   rsp_data,
  output logic         busy,
  output logic         lfsr_en,
  output logic         lfsr_seed_en,
  output logic [7:0]   lfsr_seed,
  input  logic [7:0]   lfsr_rand
);

  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int CMAX = (STEPS > SEED_CYCLES) ? STEPS : SEED_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] STEPS_LAST = CW'(STEPS);
  localparam logic [CW-1:0] SEED_LAST  = CW'(SEED_CYCLES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    ST_SEED,
    ST_IDLE,
    ST_STEP,
    ST_CAPTURE,
    ST_DELIVER
  } state_t;

  // Registered state and outputs
  state_t         state;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  cur_idx;
  logic           reseed_pend;

  // Next-state values
  state_t         state_nxt;
  logic [CW-1:0]  cnt_nxt;
  logic [IW-1:0]  ptr_nxt;
  logic [IW-1:0]  cur_idx_nxt;
  logic           reseed_pend_nxt;
  logic [N-1:0]   gnt_nxt;
  logic [N-1:0]   rsp_valid_nxt;
  logic [7:0]     rsp_data_nxt;
  logic           busy_nxt;
  logic           lfsr_en_nxt;
  logic           lfsr_seed_en_nxt;
  logic [7:0]     lfsr_seed_nxt;

  // Arbiter results
  logic           pick_found;
  logic [IW-1:0]  pick_idx;
  logic [IW-1:0]  cand;
  logic [N-1:0]   pick_onehot;

  // A zero seed would lock the LFSR, so substitute the safe seed.
  logic [7:0]     seed_pick;
  assign seed_pick = (seed_in == 8'h00) ? SAFE_SEED : seed_in;

  // Round-robin search starting one past the last served index.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    cand        = '0;
    pick_onehot = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_onehot[pick_idx] = 1'b1;
  end

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    ptr_nxt          = ptr;
    cur_idx_nxt      = cur_idx;
    reseed_pend_nxt  = reseed_pend | reseed_req;
    gnt_nxt          = gnt;
    rsp_valid_nxt    = '0;
    rsp_data_nxt     = rsp_data;
    busy_nxt         = 1'b1;
    lfsr_en_nxt      = 1'b0;
    lfsr_seed_en_nxt = 1'b0;
    lfsr_seed_nxt    = lfsr_seed;

    case (state)
      ST_SEED: begin
        if (!lfsr_seed_en) begin
          // Only reachable straight out of reset: start the load here,
          // since reset leaves the seed outputs cleared.
          lfsr_seed_en_nxt = 1'b1;
          lfsr_seed_nxt    = seed_pick;
          cnt_nxt          = CNT_ONE;
        end else if (cnt < SEED_LAST) begin
          lfsr_seed_en_nxt = 1'b1;
          cnt_nxt          = cnt + CNT_ONE;
        end else begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
        end
      end

      ST_IDLE: begin
        if (reseed_pend || reseed_req) begin
          state_nxt        = ST_SEED;
          lfsr_seed_en_nxt = 1'b1;
          lfsr_seed_nxt    = seed_pick;
          cnt_nxt          = CNT_ONE;
          reseed_pend_nxt  = 1'b0;
        end else if (pick_found) begin
          state_nxt   = ST_STEP;
          gnt_nxt     = pick_onehot;
          cur_idx_nxt = pick_idx;
          lfsr_en_nxt = 1'b1;
          cnt_nxt     = CNT_ONE;
        end else begin
          busy_nxt = 1'b0;
        end
      end

      ST_STEP: begin
        if (cnt < STEPS_LAST) begin
          lfsr_en_nxt = 1'b1;
          cnt_nxt     = cnt + CNT_ONE;
        end else begin
          state_nxt = ST_CAPTURE;
          cnt_nxt   = '0;
        end
      end

      ST_CAPTURE: begin
        // The last step landed at the start of this cycle, so lfsr_rand is final.
        rsp_data_nxt  = lfsr_rand;
        rsp_valid_nxt = gnt;
        state_nxt     = ST_DELIVER;
      end

      ST_DELIVER: begin
        ptr_nxt   = cur_idx;
        gnt_nxt   = '0;
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = ST_SEED;
        gnt_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_SEED;
      cnt          <= '0;
      ptr          <= IW'(N - 1);
      cur_idx      <= '0;
      reseed_pend  <= 1'b0;
      gnt          <= '0;
      rsp_valid    <= '0;
      rsp_data     <= 8'h00;
      busy         <= 1'b1;
      lfsr_en      <= 1'b0;
      lfsr_seed_en <= 1'b0;
      lfsr_seed    <= 8'h00;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      ptr          <= ptr_nxt;
      cur_idx      <= cur_idx_nxt;
      reseed_pend  <= reseed_pend_nxt;
      gnt          <= gnt_nxt;
      rsp_valid    <= rsp_valid_nxt;
      rsp_data     <= rsp_data_nxt;
      busy         <= busy_nxt;
      lfsr_en      <= lfsr_en_nxt;
      lfsr_seed_en <= lfsr_seed_en_nxt;
      lfsr_seed    <= lfsr_seed_nxt;
    end
  end

`ifndef SYNTHESIS
  a_en_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(lfsr_en && lfsr_seed_en));
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt));
  a_rsp_match : assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid != '0) |-> (rsp_valid == gnt));
`endif

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Purpose: self-checking bench for lfsr_share_ctrl with an add-one LFSR stub.
// Latency: follows the controller; every transaction is checked cycle by cycle.
// Backpressure: none; expected responses are queued and matched on rsp_valid.

module tb_lfsr_share_ctrl;

  localparam int STEPS = 4;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic [3:0] req        = 4'b0000;
  logic [7:0] seed_in    = 8'h10;
  logic       reseed_req = 1'b0;
  logic [3:0] gnt;
  logic [3:0] rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       lfsr_en;
  logic       lfsr_seed_en;
  logic [7:0] lfsr_seed;
  logic [7:0] lfsr_rand  = 8'h00;

  typedef struct packed {
    logic [3:0] vld;
    logic [7:0] dat;
  } exp_t;

  exp_t       sb[$];
  int         checks  = 0;
  int         passes  = 0;
  int         overlap = 0;
  logic [7:0] model_val = 8'h00;

  always #5 clk = ~clk;

  lfsr_share_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .seed_in      (seed_in),
    .reseed_req   (reseed_req),
    .gnt          (gnt),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .lfsr_en      (lfsr_en),
    .lfsr_seed_en (lfsr_seed_en),
    .lfsr_seed    (lfsr_seed),
    .lfsr_rand    (lfsr_rand)
  );

  // LFSR stub: loads the seed, otherwise adds one per enabled step.
  always @(posedge clk) begin
    if (lfsr_seed_en)
      lfsr_rand <= lfsr_seed;
    else if (lfsr_en)
      lfsr_rand <= lfsr_rand + 8'd1;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && lfsr_en === 1'b1 && lfsr_seed_en === 1'b1)
      overlap++;
  end

  // Scoreboard: every response strobe must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && rsp_valid !== 4'b0000) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: rsp_valid=%b rsp_data=%h, no response expected", rsp_valid, rsp_data);
      end else begin
        e = sb.pop_front();
        if (rsp_valid !== e.vld || rsp_data !== e.dat)
          $display("FAIL sb_rsp: got valid=%b data=%h, want valid=%b data=%h", rsp_valid, rsp_data, e.vld, e.dat);
        else
          passes++;
      end
    end
  end

  // One grant transaction, starting in an IDLE cycle.
  task automatic txn(input logic [3:0] pat, input int idx, input int drop_at,
                     input int reseed_at, input string name);
    logic [3:0] oh;
    exp_t       e;
    oh        = 4'b0001 << idx;
    req       = pat;
    model_val = model_val + 8'(STEPS);
    e.vld     = oh;
    e.dat     = model_val;
    sb.push_back(e);
    @(posedge clk);
    for (int c = 1; c <= STEPS + 2; c++) begin
      @(negedge clk);
      checks++;
      if (gnt !== oh) $display("FAIL %s_gnt c%0d: got %b want %b", name, c, gnt, oh);
      else passes++;
      checks++;
      if (lfsr_en !== (c <= STEPS)) $display("FAIL %s_lfsr_en c%0d: got %b want %b", name, c, lfsr_en, (c <= STEPS));
      else passes++;
      checks++;
      if (rsp_valid !== ((c == STEPS + 2) ? oh : 4'b0000))
        $display("FAIL %s_rsp_valid c%0d: got %b want %b", name, c, rsp_valid, (c == STEPS + 2) ? oh : 4'b0000);
      else passes++;
      checks++;
      if (busy !== 1'b1 || lfsr_seed_en !== 1'b0)
        $display("FAIL %s_busy_seed c%0d: got busy=%b seed_en=%b want 1/0", name, c, busy, lfsr_seed_en);
      else passes++;
      if (c == drop_at) req = 4'b0000;
      reseed_req = (c == reseed_at);
    end
    reseed_req = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || rsp_valid !== 4'b0000 || rsp_data !== model_val)
      $display("FAIL %s_idle: got gnt=%b busy=%b rsp_valid=%b data=%h want 0000/0/0000/%h",
               name, gnt, busy, rsp_valid, rsp_data, model_val);
    else passes++;
  endtask

  task automatic apply_reset(input logic [7:0] seed);
    @(negedge clk);
    rst_n      = 1'b0;
    req        = 4'b0000;
    reseed_req = 1'b0;
    seed_in    = seed;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_seed_timeout: busy=%b want 0", busy);
    else passes++;
    model_val = (seed == 8'h00) ? 8'hA5 : seed;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || rsp_valid !== 4'b0000 || rsp_data !== 8'h00)
      $display("FAIL rst_outputs: gnt=%b rsp_valid=%b rsp_data=%h want all zero", gnt, rsp_valid, rsp_data);
    else passes++;
    checks++;
    if (busy !== 1'b1 || lfsr_en !== 1'b0 || lfsr_seed_en !== 1'b0 || lfsr_seed !== 8'h00)
      $display("FAIL rst_ctrl: busy=%b en=%b seed_en=%b seed=%h want 1/0/0/00", busy, lfsr_en, lfsr_seed_en, lfsr_seed);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (lfsr_seed_en !== 1'b1 || lfsr_seed !== 8'h10 || busy !== 1'b1 || lfsr_en !== 1'b0)
      $display("FAIL seed_c1: seed_en=%b seed=%h busy=%b en=%b want 1/10/1/0", lfsr_seed_en, lfsr_seed, busy, lfsr_en);
    else passes++;
    @(negedge clk);
    checks++;
    if (lfsr_seed_en !== 1'b1 || busy !== 1'b1)
      $display("FAIL seed_c2: seed_en=%b busy=%b want 1/1", lfsr_seed_en, busy);
    else passes++;
    @(negedge clk);
    checks++;
    if (lfsr_seed_en !== 1'b0 || busy !== 1'b0 || lfsr_rand !== 8'h10)
      $display("FAIL seed_c3: seed_en=%b busy=%b lfsr=%h want 0/0/10", lfsr_seed_en, busy, lfsr_rand);
    else passes++;
    model_val = 8'h10;
  endtask

  task automatic test_single;
    txn(4'b0001, 0, 1, 0, "single1");
    txn(4'b0001, 0, 1, 0, "single2");
  endtask

  task automatic test_round_robin;
    apply_reset(8'h10);
    txn(4'b1111, 0, 0, 0, "rr0");
    txn(4'b1111, 1, 0, 0, "rr1");
    txn(4'b1111, 2, 0, 0, "rr2");
    txn(4'b1111, 3, 0, 0, "rr3");
    txn(4'b1111, 0, 1, 0, "rr4");
  endtask

  task automatic test_reseed;
    seed_in = 8'h00;
    txn(4'b0010, 1, 0, 2, "reseed_txn");
    @(negedge clk);
    checks++;
    if (lfsr_seed_en !== 1'b1 || lfsr_seed !== 8'hA5 || gnt !== 4'b0000 || busy !== 1'b1 || lfsr_en !== 1'b0)
      $display("FAIL reseed_c1: seed_en=%b seed=%h gnt=%b busy=%b en=%b want 1/a5/0000/1/0",
               lfsr_seed_en, lfsr_seed, gnt, busy, lfsr_en);
    else passes++;
    @(negedge clk);
    checks++;
    if (lfsr_seed_en !== 1'b1 || gnt !== 4'b0000)
      $display("FAIL reseed_c2: seed_en=%b gnt=%b want 1/0000", lfsr_seed_en, gnt);
    else passes++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0000 || lfsr_seed_en !== 1'b0)
      $display("FAIL reseed_idle: busy=%b gnt=%b seed_en=%b want 0/0000/0", busy, gnt, lfsr_seed_en);
    else passes++;
    model_val = 8'hA5;
    txn(4'b0010, 1, 1, 0, "after_reseed");
  endtask

  task automatic test_reset_abort;
    req = 4'b0001;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (gnt !== 4'b0001 || lfsr_en !== 1'b1)
      $display("FAIL abort_pre: gnt=%b en=%b want 0001/1", gnt, lfsr_en);
    else passes++;
    #2;
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    checks++;
    if (gnt !== 4'b0000 || rsp_valid !== 4'b0000 || rsp_data !== 8'h00 || busy !== 1'b1 ||
        lfsr_en !== 1'b0 || lfsr_seed_en !== 1'b0 || lfsr_seed !== 8'h00)
      $display("FAIL abort_reset: gnt=%b rv=%b data=%h busy=%b en=%b sen=%b seed=%h want 0/0/00/1/0/0/00",
               gnt, rsp_valid, rsp_data, busy, lfsr_en, lfsr_seed_en, lfsr_seed);
    else passes++;
    seed_in = 8'h33;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (lfsr_seed_en !== 1'b1 || lfsr_seed !== 8'h33)
      $display("FAIL abort_reseed: seed_en=%b seed=%h want 1/33", lfsr_seed_en, lfsr_seed);
    else passes++;
    for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL abort_idle_timeout: busy=%b want 0", busy);
    else passes++;
    model_val = 8'h33;
    txn(4'b0001, 0, 1, 0, "post_abort");
  endtask

  task automatic test_drop_req;
    txn(4'b0100, 2, 2, 0, "drop");
    txn(4'b1111, 3, 1, 0, "ptr_adv");
  endtask

  task automatic test_final;
    checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover: %0d responses missing, want 0", sb.size());
    else passes++;
    checks++;
    if (overlap != 0) $display("FAIL en_overlap: %0d cycles with both enables, want 0", overlap);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_reseed();
    test_reset_abort();
    test_drop_req();
    test_final();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
